// File: rtl/papuf_challenger.sv
// Challenge generator / majority voter for the papuf array: LFSR challenges, pulse, settle, sample, vote.
// Optional PAPUF_STABILITY_EN adds resp_unstable_o flagging bits whose votes were not unanimous.
module papuf_challenger #(
  parameter int RESP_W        = 16,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int VOTES         = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [15:0]       seed_i,
  input  logic [7:0]        num_chal_i,
  output logic [15:0]       challenge_o,
  output logic              pulse_o,
  input  logic [RESP_W-1:0] response_i,
  output logic              busy_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [RESP_W-1:0] resp_data_o,
  output logic [15:0]       resp_chal_o,
  output logic              done_o
`ifdef PAPUF_STABILITY_EN
  ,
  output logic [RESP_W-1:0] resp_unstable_o
`endif
);

  localparam int OW     = $clog2(VOTES + 1);
  localparam int VW     = 4;
  localparam int PH_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PULSE, S_SETTLE, S_SAMPLE, S_OUT, S_DONE
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] c);
    return {c[14:0], c[15] ^ c[13] ^ c[12] ^ c[10]};
  endfunction

  function automatic logic majority(input logic [OW-1:0] n);
    return n > OW'(VOTES / 2);
  endfunction

  state_t              state_q, state_d;
  logic [PHW-1:0]      cnt_q, cnt_d;
  logic [VW-1:0]       vote_q, vote_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [15:0]         chal_q, chal_d;
  logic [7:0]          rem_q, rem_d;
  logic [OW-1:0]       ones_q [RESP_W];
  logic [OW-1:0]       ones_d [RESP_W];
  logic [RESP_W-1:0]   sync1_q, sync2_q;

  // response crosses in from the array asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= response_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vote_q  <= '0;
      lfsr_q  <= '0;
      chal_q  <= '0;
      rem_q   <= '0;
      for (int i = 0; i < RESP_W; i++) ones_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vote_q  <= vote_d;
      lfsr_q  <= lfsr_d;
      chal_q  <= chal_d;
      rem_q   <= rem_d;
      for (int i = 0; i < RESP_W; i++) ones_q[i] <= ones_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vote_d  = vote_q;
    lfsr_d  = lfsr_q;
    chal_d  = chal_q;
    rem_d   = rem_q;
    for (int i = 0; i < RESP_W; i++) ones_d[i] = ones_q[i];
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lfsr_d  = (seed_i == 16'h0000) ? 16'hACE1 : seed_i;
          rem_d   = num_chal_i;
          state_d = (num_chal_i != 8'd0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        chal_d  = lfsr_q;
        vote_d  = '0;
        cnt_d   = '0;
        for (int i = 0; i < RESP_W; i++) ones_d[i] = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == PHW'(PULSE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + PHW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == PHW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + PHW'(1);
        end
      end
      S_SAMPLE: begin
        for (int i = 0; i < RESP_W; i++) ones_d[i] = ones_q[i] + OW'(sync2_q[i]);
        vote_d  = vote_q + VW'(1);
        state_d = (vote_q == VW'(VOTES - 1)) ? S_OUT : S_PULSE;
      end
      S_OUT: begin
        // the challenge sequence only moves once the consumer takes the word
        if (resp_ready_i) begin
          lfsr_d  = lfsr_next(lfsr_q);
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign challenge_o  = chal_q;
  assign resp_chal_o  = chal_q;
  assign pulse_o      = (state_q == S_PULSE);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = (state_q == S_OUT);
  assign done_o       = (state_q == S_DONE);

  always_comb begin
    resp_data_o = '0;
    for (int i = 0; i < RESP_W; i++) resp_data_o[i] = majority(ones_q[i]);
  end

`ifdef PAPUF_STABILITY_EN
  always_comb begin
    resp_unstable_o = '0;
    for (int i = 0; i < RESP_W; i++)
      resp_unstable_o[i] = (ones_q[i] != '0) && (ones_q[i] != OW'(VOTES));
  end
`endif

endmodule

// File: tb/tb_papuf_challenger.sv
// Directed bench for papuf_challenger: a queue-based model of expected voted words plus literal checks.
module tb_papuf_challenger;

  localparam int VOTES = 5;
  localparam int PULSE_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] seed;
  logic [7:0]  num_chal;
  logic [15:0] challenge;
  logic        pulse;
  logic [15:0] response = 16'h0000;
  logic        busy;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [15:0] resp_chal;
  logic        done;
`ifdef PAPUF_STABILITY_EN
  logic [15:0] resp_unstable;
`endif

  papuf_challenger dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .seed_i       (seed),
    .num_chal_i   (num_chal),
    .challenge_o  (challenge),
    .pulse_o      (pulse),
    .response_i   (response),
    .busy_o       (busy),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_chal_o  (resp_chal),
    .done_o       (done)
`ifdef PAPUF_STABILITY_EN
    ,
    .resp_unstable_o (resp_unstable)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] chal;
    logic [15:0] data;
    logic [15:0] unst;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] resp_tab [VOTES];
  int          npulse = 0;
  int          base_pulse = 0;
  int          npass = 0;
  int          ntot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] c);
    return {c[14:0], c[15] ^ c[13] ^ c[12] ^ c[10]};
  endfunction

  // per-bit count of ones across the vote table
  function automatic int ones_of(input int b);
    int n = 0;
    for (int v = 0; v < VOTES; v++) if (resp_tab[v][b]) n++;
    return n;
  endfunction

  task automatic push_run(input logic [15:0] s, input int n);
    exp_t e;
    logic [15:0] l;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    for (int k = 0; k < n; k++) begin
      e.chal = l;
      e.data = '0;
      e.unst = '0;
      for (int b = 0; b < 16; b++) begin
        e.data[b] = (ones_of(b) > VOTES / 2);
        e.unst[b] = (ones_of(b) != 0) && (ones_of(b) != VOTES);
      end
      exp_q.push_back(e);
      l = model_step(l);
    end
  endtask

  task automatic set_tab(input logic [15:0] v);
    for (int i = 0; i < VOTES; i++) resp_tab[i] = v;
  endtask

  task automatic start_run(input logic [15:0] s, input logic [7:0] n);
    base_pulse = npulse;
    seed = s;
    num_chal = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!resp_valid && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) chk("timeout_valid", 32'(resp_valid), 32'd1);
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  // each evaluation pulse presents the next entry of the vote table
  initial begin
    forever begin
      @(posedge pulse);
      response = resp_tab[(npulse - base_pulse) % VOTES];
      npulse++;
    end
  end

  // compare process: DUT stream against the model queue every cycle
  initial begin
    int  pulse_hi = 0;
    bit  prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pulse_hi = 0;
        prev_valid = 1'b0;
      end else begin
        if (resp_valid) begin
          if (!prev_valid) begin
            chk("pulse_cycles_per_word", 32'(pulse_hi), 32'(VOTES * PULSE_CYCLES));
            pulse_hi = 0;
          end
          chk("pulse_during_valid", 32'(pulse), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(resp_valid), 32'd0);
          end else begin
            chk("model_chal", 32'(resp_chal), 32'(exp_q[0].chal));
            chk("model_data", 32'(resp_data), 32'(exp_q[0].data));
`ifdef PAPUF_STABILITY_EN
            chk("model_unstable", 32'(resp_unstable), 32'(exp_q[0].unst));
`endif
            if (resp_ready) void'(exp_q.pop_front());
          end
        end
        if (pulse) pulse_hi++;
        if (done) chk("done_with_pending_words", 32'(exp_q.size()), 32'd0);
        prev_valid = resp_valid;
      end
    end
  end

  initial begin
    int n;
    int k;
    logic [15:0] got [4];
    rst_n = 1'b0;
    start = 1'b0;
    seed = '0;
    num_chal = '0;
    resp_ready = 1'b0;
    set_tab(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_challenge", 32'(challenge), 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single challenge, constant response
    set_tab(16'hA5A5);
    resp_ready = 1'b1;
    push_run(16'h0001, 1);
    start_run(16'h0001, 8'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_valid(200, n);
    chk("t1_latency", 32'(n), 32'd56);
    chk("t1_data", 32'(resp_data), 32'h0000A5A5);
    chk("t1_chal", 32'(resp_chal), 32'h00000001);
    @(posedge clk); #1;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_pulses", 32'(npulse - base_pulse), 32'd5);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // LFSR sequence across three challenges
    set_tab(16'h3C3C);
    push_run(16'h0001, 3);
    start_run(16'h0001, 8'd3);
    k = 0;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      if (resp_valid && k < 4) begin
        got[k] = resp_chal;
        k++;
      end
      n++;
    end
    chk("t2_words", 32'(k), 32'd3);
    chk("t2_chal0", 32'(got[0]), 32'h00000001);
    chk("t2_chal1", 32'(got[1]), 32'h00000002);
    chk("t2_chal2", 32'(got[2]), 32'h00000004);
    @(posedge clk); #1;

    // split vote on bit0 (ones on the 1st and 3rd votes only)
    set_tab(16'h5A5A);
    resp_tab[0] = 16'h5A5B;
    resp_tab[2] = 16'h5A5B;
    push_run(16'h0001, 1);
    start_run(16'h0001, 8'd1);
    wait_valid(200, n);
    chk("t3_data", 32'(resp_data), 32'h00005A5A);
`ifdef PAPUF_STABILITY_EN
    chk("t3_unstable", 32'(resp_unstable), 32'h00000001);
`endif
    wait_done(10);

    // consumer back-pressure
    set_tab(16'h1234);
    resp_ready = 1'b0;
    push_run(16'h00F0, 2);
    start_run(16'h00F0, 8'd2);
    wait_valid(200, n);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 32'(resp_valid), 32'd1);
      chk("t4_hold_chal", 32'(resp_chal), 32'h000000F0);
      chk("t4_hold_data", 32'(resp_data), 32'h00001234);
      chk("t4_hold_pulse", 32'(pulse), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    wait_valid(200, n);
    chk("t4_next_chal", 32'(resp_chal), 32'h000001E0);
    wait_done(10);

    // zero seed substitution, then an empty run
    set_tab(16'h0F0F);
    push_run(16'h0000, 1);
    start_run(16'h0000, 8'd1);
    wait_valid(200, n);
    chk("t5_seed0_chal", 32'(resp_chal), 32'h0000ACE1);
    wait_done(10);
    start_run(16'h1111, 8'd0);
    chk("t5_empty_done", 32'(done), 32'd1);
    chk("t5_empty_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("t5_empty_done_low", 32'(done), 32'd0);
    chk("t5_empty_idle", 32'(busy), 32'd0);

    // reset in the middle of a pulse
    start_run(16'h0003, 8'd2);
    n = 0;
    while (!pulse && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_pulse_seen", 32'(pulse), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_pulse_drop", 32'(pulse), 32'd0);
    chk("t6_busy_drop", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_run(16'h0003, 1);
    start_run(16'h0003, 8'd1);
    wait_valid(200, n);
    chk("t6_clean_latency", 32'(n), 32'd56);
    chk("t6_clean_chal", 32'(resp_chal), 32'h00000003);
    chk("t6_clean_data", 32'(resp_data), 32'h00000F0F);
    wait_done(10);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
